// File: rtl/bb_skid_buf.sv
// Two-entry valid/ready skid buffer with fully registered data, valid and ready
// outputs, one transfer per cycle sustained, and a synchronous flush.
module bb_skid_buf #(
  parameter int            DW      = 32,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_data,
  output logic [1:0]    occupancy
);

  // The state encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          s_ready_q, s_ready_d;
  logic          m_valid_q, m_valid_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;
  logic          s_fire, m_fire;

  assign s_fire = s_valid & s_ready_q;
  assign m_fire = m_valid_q & m_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= EMPTY;
      s_ready_q <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_ready_q <= s_ready_d;
      m_valid_q <= m_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      EMPTY: if (s_fire) state_d = ONE;
      ONE: begin
        if (s_fire && !m_fire)      state_d = FULL;
        else if (!s_fire && m_fire) state_d = EMPTY;
      end
      FULL:    if (m_fire) state_d = ONE;
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  // Handshake outputs are precomputed from the next state so they leave flops.
  always_comb begin
    s_ready_d = (state_d != FULL);
    m_valid_d = (state_d != EMPTY);
    main_d    = main_q;
    skid_d    = skid_q;
    if (!flush) begin
      unique case (state_q)
        EMPTY: if (s_fire) main_d = s_data;
        ONE: begin
          if (s_fire && m_fire)       main_d = s_data;
          else if (s_fire && !m_fire) skid_d = s_data;
        end
        FULL:    if (m_fire) main_d = skid_q;
        default: ;
      endcase
    end
  end

  // Flush leaves the payload registers untouched; only reset reloads them.
  always_ff @(posedge clk) begin
    if (rst) begin
      main_q <= RST_VAL;
      skid_q <= RST_VAL;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

  assign s_ready   = s_ready_q;
  assign m_valid   = m_valid_q;
  assign m_data    = main_q;
  assign occupancy = state_q;

endmodule

// File: tb/tb_bb_skid_buf.sv
// Scoreboard bench for bb_skid_buf: a queue of accepted words models the buffer;
// a monitor checks every cycle's outputs against it and pops on each output beat.
module tb_bb_skid_buf;
  localparam int            DW      = 32;
  localparam logic [DW-1:0] RST_VAL = 32'h0BAD_F00D;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          sValid = 1'b0;
  logic          mReady = 1'b0;
  logic [DW-1:0] sData = '0;
  logic          sReady, mValid;
  logic [DW-1:0] mData;
  logic [1:0]    occupancy;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] sbQ[$];
  logic [DW-1:0] outLog[$];
  logic [DW-1:0] expQ[$];
  bit            modelKnown = 1'b0;
  bit            modelUp = 1'b0;
  bit            expSReady = 1'b0;
  bit            prevStall = 1'b0;
  logic [DW-1:0] headSeen;
  logic [DW-1:0] prevData;

  bb_skid_buf #(.DW(DW), .RST_VAL(RST_VAL)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .s_valid(sValid), .s_ready(sReady), .s_data(sData),
    .m_valid(mValid), .m_ready(mReady), .m_data(mData),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [DW-1:0] actual,
                             input logic [DW-1:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkLog(input string name);
    checkOutput({name, "_count"}, DW'(outLog.size()), DW'(expQ.size()));
    foreach (expQ[i])
      if (i < outLog.size()) checkOutput(name, outLog[i], expQ[i]);
  endtask

  task automatic applyStimulus(input bit r, input bit f, input bit sv,
                               input logic [DW-1:0] d, input bit mr);
    @(posedge clk);
    #1;
    rst = r; flush = f; sValid = sv; sData = d; mReady = mr;
  endtask

  // Model update on each edge: reset and flush empty it, else accepted words queue up.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      sbQ.delete();
      modelKnown = 1'b1;
      modelUp = 1'b0;
      headSeen = RST_VAL;
    end else if (flush) begin
      sbQ.delete();
      modelUp = 1'b1;
    end else begin
      if (sValid && expSReady) sbQ.push_back(sData);
      modelUp = 1'b1;
    end
  end

  // Monitor: compare outputs mid-cycle, then pop the front on a delivered beat.
  initial forever begin
    @(negedge clk);
    if (modelKnown) begin
      expSReady = modelUp && (sbQ.size() < 2);
      checkOutput("s_ready", DW'(sReady), DW'(expSReady));
      checkOutput("m_valid", DW'(mValid), DW'(sbQ.size() > 0));
      checkOutput("occupancy", DW'(occupancy), DW'(sbQ.size()));
      if (sbQ.size() > 0) headSeen = sbQ[0];
      checkOutput("m_data", mData, headSeen);
      if (prevStall) begin
        checkOutput("stall_valid", DW'(mValid), DW'(1));
        checkOutput("stall_data", mData, prevData);
      end
      prevStall = mValid && !mReady && !rst && !flush;
      prevData = mData;
      if (mValid && mReady && !rst && !flush) begin
        if (sbQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_beat actual=%h required=none", mData);
        end else begin
          outLog.push_back(sbQ.pop_front());
        end
      end
    end
  end

  initial begin
    // Reset held two cycles with a word already offered upstream.
    rst = 1'b1; sValid = 1'b1; sData = 32'hA5;
    applyStimulus(1, 0, 1, 32'hA5, 0);
    applyStimulus(0, 0, 1, 32'hA5, 0);
    applyStimulus(0, 0, 1, 32'hA5, 0);
    applyStimulus(0, 0, 0, '0, 1);
    @(negedge clk);
    checkOutput("t1_m_data", mData, 32'hA5);
    applyStimulus(0, 0, 0, '0, 1);
    expQ.delete(); expQ.push_back(32'hA5);
    checkLog("t1_log");

    outLog.delete();
    for (int i = 0; i < 16; i++) applyStimulus(0, 0, 1, DW'(i), 1);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 1);
    expQ.delete();
    for (int i = 0; i < 16; i++) expQ.push_back(DW'(i));
    checkLog("t2_stream");

    outLog.delete();
    applyStimulus(0, 0, 1, 32'h11, 0);
    applyStimulus(0, 0, 1, 32'h22, 0);
    applyStimulus(0, 0, 1, 32'h33, 0);
    @(negedge clk);
    checkOutput("t3_occ_full", DW'(occupancy), DW'(2));
    checkOutput("t3_sready_low", DW'(sReady), DW'(0));
    applyStimulus(0, 0, 1, 32'h33, 1);
    applyStimulus(0, 0, 1, 32'h33, 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, '0, 1);
    expQ.delete(); expQ.push_back(32'h11); expQ.push_back(32'h22); expQ.push_back(32'h33);
    checkLog("t3_order");

    outLog.delete();
    applyStimulus(0, 0, 1, 32'h41, 0);
    applyStimulus(0, 0, 1, 32'h42, 0);
    applyStimulus(0, 1, 1, 32'h44, 1);
    applyStimulus(0, 0, 0, '0, 1);
    @(negedge clk);
    checkOutput("t4_m_valid", DW'(mValid), DW'(0));
    checkOutput("t4_occ", DW'(occupancy), DW'(0));
    checkOutput("t4_s_ready", DW'(sReady), DW'(1));
    applyStimulus(0, 0, 1, 32'h55, 1);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 1);
    expQ.delete(); expQ.push_back(32'h55);
    checkLog("t4_flush");

    outLog.delete();
    applyStimulus(0, 0, 1, 32'h61, 0);
    applyStimulus(0, 0, 0, '0, 0);
    applyStimulus(1, 0, 0, '0, 0);
    applyStimulus(0, 0, 0, '0, 1);
    @(negedge clk);
    checkOutput("t6_m_valid", DW'(mValid), DW'(0));
    checkOutput("t6_m_data", mData, RST_VAL);
    applyStimulus(0, 0, 0, '0, 1);
    applyStimulus(0, 0, 0, '0, 1);
    expQ.delete();
    checkLog("t6_rst");

    for (int i = 0; i < 10000; i++)
      applyStimulus(0, $urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                    $urandom, $urandom_range(0, 3) != 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, '0, 1);
    @(negedge clk);
    checkOutput("t5_drained", DW'(occupancy), DW'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
